sa_cache_ctrl: RTL and testbench

SA_CACHE_CTRL -- requirements
Module: sa_cache_ctrl

---
 rtl/sa_cache_pkg.sv | 26 ++
 rtl/sa_cache_if.sv | 30 +++
 rtl/sa_cache_ctrl_plru.sv | 39 +++
 rtl/sa_cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sa_cache_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sa_cache_pkg.sv
// Shared types and geometry for the 4-set, 4-way write-through cache controller.
package sa_cache_pkg;

    localparam int unsigned TAG_W    = 26;
    localparam int unsigned SET_W    = 2;
    localparam int unsigned WORD_W   = 2;
    localparam int unsigned NUM_SETS = 4;
    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned LINE_W   = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StWrmem,
        StResp
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SET_W-1:0]  set;
        logic [WORD_W-1:0] word;
        logic [1:0]        byte_off;
    } addr_t;

endpackage

// File: rtl/sa_cache_if.sv
// CPU-side and memory-side bus of the cache controller.
interface sa_cache_if;
    import sa_cache_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_done;
    logic [31:0]       cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    // slave: the cache controller; master: the CPU and memory around it
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sa_cache_ctrl_plru.sv
// Victim selection and tree-PLRU update for the three PLRU bits of one set.
module sa_plru (
    input  logic [2:0] plru_i,
    input  logic [3:0] valid_i,
    input  logic [1:0] way_i,
    output logic [1:0] victim_o,
    output logic [2:0] plru_o
);

    // Invalid ways are filled lowest-first before the tree is consulted
    always_comb begin
        victim_o = 2'd0;
        if (!valid_i[0]) begin
            victim_o = 2'd0;
        end else if (!valid_i[1]) begin
            victim_o = 2'd1;
        end else if (!valid_i[2]) begin
            victim_o = 2'd2;
        end else if (!valid_i[3]) begin
            victim_o = 2'd3;
        end else if (!plru_i[0]) begin
            victim_o = {1'b0, plru_i[1]};
        end else begin
            victim_o = {1'b1, plru_i[2]};
        end
    end

    always_comb begin
        plru_o = plru_i;
        if (!way_i[1]) begin
            plru_o[0] = 1'b1;
            plru_o[1] = (way_i == 2'd0);
        end else begin
            plru_o[0] = 1'b0;
            plru_o[2] = (way_i == 2'd2);
        end
    end

endmodule

// File: rtl/sa_cache_ctrl.sv
// 4-set, 4-way, write-through / no-write-allocate cache controller with
// tree-PLRU replacement and saturating hit/miss counters.
module sa_cache_ctrl
    import sa_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    sa_cache_if.slave   bus,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
);

    state_e state_q, state_d;

    logic        we_q;
    addr_t       addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [2:0]          plru_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

    logic              hit;
    logic [1:0]        hit_way;
    logic [1:0]        victim;
    logic [1:0]        upd_way;
    logic [2:0]        plru_upd;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [31:0]       refill_word;
    logic              lookup_hit;
    logic              lookup_miss;
    logic              refill_done;

    // Downward scan so the lowest matching way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_q.set][w] && (tag_q[addr_q.set][w] == addr_q.tag)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    assign hit_line    = data_q[addr_q.set][hit_way];
    assign hit_word    = hit_line[{addr_q.word, 5'b0} +: 32];
    assign refill_word = bus.mem_rdata[{addr_q.word, 5'b0} +: 32];
    assign lookup_hit  = (state_q == StLookup) && hit;
    assign lookup_miss = (state_q == StLookup) && !hit;
    assign refill_done = (state_q == StRefill) && bus.mem_ack;
    assign upd_way     = (state_q == StRefill) ? victim : hit_way;

    sa_plru u_plru (
        .plru_i   (plru_q[addr_q.set]),
        .valid_i  (valid_q[addr_q.set]),
        .way_i    (upd_way),
        .victim_o (victim),
        .plru_o   (plru_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!flush_i && bus.cpu_req) state_d = StLookup;
            StLookup: state_d = we_q ? StWrmem : (hit ? StResp : StRefill);
            StRefill: if (bus.mem_ack) state_d = StResp;
            StWrmem:  if (bus.mem_ack) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cpu_done  = (state_q == StResp);
        bus.cpu_rdata = rdata_q;
        busy_o        = (state_q != StIdle);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            StRefill: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q.tag, addr_q.set, 4'b0000};
            end
            StWrmem: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Byte offset is zeroed on capture, so addr_q doubles as the word address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == StIdle) && !flush_i && bus.cpu_req) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr & 32'hFFFF_FFFC;
                wdata_q <= bus.cpu_wdata;
            end
            if (lookup_hit && !we_q) begin
                rdata_q <= hit_word;
            end else if (refill_done) begin
                rdata_q <= refill_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (lookup_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else if ((state_q == StIdle) && flush_i) begin
            valid_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            if (lookup_hit) begin
                plru_q[addr_q.set] <= plru_upd;
            end
            if (refill_done) begin
                valid_q[addr_q.set][victim] <= 1'b1;
                plru_q[addr_q.set]          <= plru_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lookup_hit && we_q) begin
            data_q[addr_q.set][hit_way][{addr_q.word, 5'b0} +: 32] <= wdata_q;
        end
        if (refill_done) begin
            data_q[addr_q.set][victim] <= bus.mem_rdata;
            tag_q[addr_q.set][victim]  <= addr_q.tag;
        end
    end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed bench for sa_cache_ctrl: reference memory model, read-data scoreboard
// and hit/miss counter model.
module tb_sa_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem_wr [logic [31:0]];
    logic [15:0] exp_hits = '0;
    logic [15:0] exp_miss = '0;

    sa_cache_if bus ();

    sa_cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush_i    (flush),
        .busy_o     (busy),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_wr.exists(wa)) return mem_wr[wa];
        return wa ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [127:0] line_at(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'b0000};
        return {word_at(b + 32'd12), word_at(b + 32'd8), word_at(b + 32'd4), word_at(b)};
    endfunction

    function automatic logic [31:0] set1(input int k, input int w);
        return (32'(k) << 6) | 32'h10 | (32'(w) << 2);
    endfunction

    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_hit, input bit with_flush);
        bit          exp_mem;
        bit          got_mem;
        bit          seen_done;
        int          cyc;
        logic [31:0] exp_ma;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        exp_mem   = we || !exp_hit;
        got_mem   = 1'b0;
        seen_done = 1'b0;
        cyc       = 0;
        rdata     = '0;
        exp_ma    = we ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};

        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        if (!we) exp_q.push_back(word_at(addr));
        if (with_flush) begin
            flush = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            check({name, "_flush_idle"}, 128'(busy), 128'(1'b0));
        end

        while (!seen_done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.mem_req && !got_mem) begin
                got_mem = 1'b1;
                check({name, "_mem_we"}, 128'(bus.mem_we), 128'(we));
                check({name, "_mem_addr"}, 128'(bus.mem_addr), 128'(exp_ma));
                if (we) begin
                    check({name, "_mem_wdata"}, 128'(bus.mem_wdata), 128'(wdata));
                    mem_wr[exp_ma] = wdata;
                end
                repeat (2) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                check({name, "_mem_hold"}, 128'({bus.mem_req, bus.mem_addr}),
                      128'({1'b1, exp_ma}));
                bus.mem_rdata = line_at(exp_ma);
                bus.mem_ack   = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.mem_ack = 1'b0;
                check({name, "_mem_drop"}, 128'(bus.mem_req), 128'(1'b0));
                check({name, "_done_after_ack"}, 128'(bus.cpu_done), 128'(1'b1));
            end
            if (bus.cpu_done) begin
                seen_done = 1'b1;
                rdata     = bus.cpu_rdata;
            end
        end
        bus.cpu_req = 1'b0;

        check({name, "_done"}, 128'(seen_done), 128'(1'b1));
        check({name, "_mem_used"}, 128'(got_mem), 128'(exp_mem));
        if (!exp_mem) check({name, "_latency"}, 128'(cyc), 128'(2));
        if (!we) begin
            exp_rd = exp_q.pop_front();
            if (seen_done) check({name, "_rdata"}, 128'(rdata), 128'(exp_rd));
        end
        if (exp_hit) begin
            if (exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
        end else begin
            if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
        end

        @(negedge clk);
        check({name, "_idle"}, 128'({busy, bus.cpu_done}), 128'(2'b00));
        check({name, "_hit_cnt"}, 128'(hit_cnt), 128'(exp_hits));
        check({name, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
    endtask

    initial begin
        bit got;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 128'({busy, bus.cpu_done, bus.mem_req, bus.mem_we}), 128'(4'b0000));
        check("rst_data", 128'({bus.cpu_rdata, bus.mem_addr, bus.mem_wdata}), 128'(0));
        check("rst_cnt", 128'({hit_cnt, miss_cnt}), 128'(0));
        rst_n = 1'b1;

        // Cold miss then warm hit
        access("cold_rd", 1'b0, 32'h0000_0014, 32'h0, 1'b0, 1'b0);
        access("warm_rd", 1'b0, 32'h0000_0014, 32'h0, 1'b1, 1'b0);

        // Flush, then fill set 1 and exercise replacement
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        access("t0_fill", 1'b0, set1(0, 1), 32'h0, 1'b0, 1'b0);
        access("t1_fill", 1'b0, set1(1, 0), 32'h0, 1'b0, 1'b0);
        access("t2_fill", 1'b0, set1(2, 3), 32'h0, 1'b0, 1'b0);
        access("t3_fill", 1'b0, set1(3, 2), 32'h0, 1'b0, 1'b0);
        access("t4_evict", 1'b0, set1(4, 1), 32'h0, 1'b0, 1'b0);
        access("t1_touch", 1'b0, set1(1, 3), 32'h0, 1'b1, 1'b0);
        access("t5_evict", 1'b0, set1(5, 0), 32'h0, 1'b0, 1'b0);
        access("t3_kept", 1'b0, set1(3, 0), 32'h0, 1'b1, 1'b0);
        access("t4_kept", 1'b0, set1(4, 2), 32'h0, 1'b1, 1'b0);
        access("t1_kept", 1'b0, set1(1, 1), 32'h0, 1'b1, 1'b0);
        access("t5_kept", 1'b0, set1(5, 3), 32'h0, 1'b1, 1'b0);
        access("t2_gone", 1'b0, set1(2, 0), 32'h0, 1'b0, 1'b0);

        // Write-through hit, write miss without allocation
        access("wr_hit", 1'b1, set1(1, 2), 32'h0000_CAFE, 1'b1, 1'b0);
        access("rd_cafe", 1'b0, set1(1, 2), 32'h0, 1'b1, 1'b0);
        access("wr_miss", 1'b1, 32'h0000_1DF8, 32'h1234_5678, 1'b0, 1'b0);
        access("rd_wmiss", 1'b0, 32'h0000_1DF8, 32'h0, 1'b0, 1'b0);

        // Flush concurrent with a request
        access("flush_req", 1'b0, set1(1, 0), 32'h0, 1'b0, 1'b1);

        // Hit counter saturation
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFE;
        #1;
        release dut.hit_cnt_q;
        exp_hits = 16'hFFFE;
        check("sat_preload", 128'(hit_cnt), 128'(16'hFFFE));
        access("sat_hit0", 1'b0, set1(1, 0), 32'h0, 1'b1, 1'b0);
        access("sat_hit1", 1'b0, set1(1, 1), 32'h0, 1'b1, 1'b0);
        access("sat_hit2", 1'b0, set1(1, 2), 32'h0, 1'b1, 1'b0);
        check("sat_final", 128'(hit_cnt), 128'(16'hFFFF));

        // Reset in the middle of a refill
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_4000;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = bus.mem_req;
        end
        check("rstm_refill", 128'(got), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        bus.cpu_req = 1'b0;
        check("rstm_drop", 128'({bus.mem_req, busy}), 128'(2'b00));
        check("rstm_cnt", 128'({hit_cnt, miss_cnt}), 128'(0));
        @(negedge clk);
        rst_n         = 1'b1;
        bus.mem_rdata = line_at(32'h0000_4000);
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack", 128'({busy, bus.mem_req, bus.cpu_done}), 128'(3'b000));
        exp_hits = '0;
        exp_miss = '0;
        access("post_rst", 1'b0, 32'h0000_0014, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
